ng_wrb: RTL and testbench

- Write-bus receiver and central register file: the consuming end of the write bus driven by the bus arbiter.
- Captures WRITE_BUS into the A, Q, Z, LP and B registers on CLK2 under active-low write control pulses.
- Handles Z auto-increment and A-register overflow detection.
- Drives the AREG/QREG/ZREG/LPREG read buses back to the arbiter.

---
 rtl/ng_wrb.sv | 129 ++++++++++++
 tb/tb_ng_wrb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ng_wrb.sv
// ng_wrb: write-bus receiver and central register file.
// Captures WRITE_BUS into A, Q, Z, LP and B on the CLK2 rising edge under active-low
// control pulses. It also handles Z auto-increment and sticky A-overflow detection, and it
// drives the register read buses back to the arbiter.
//
// Ports:
//   CLK2          write clock, all state updates on the rising edge
//   NPURST        asynchronous active-low reset
//   CP[100:0]     active-low control pulse vector (bit positions given by the Cp* localparams)
//   S_ADDR[11:0]  S register address, decoded by WSC
//   WRITE_BUS     value to store
//   *_RD_BUS      continuous register contents
//   OVF           sticky A overflow flag
//   WR_STB        high for the cycle after any edge that loaded a register
module ng_wrb #(
  parameter int unsigned      WIDTH   = 16,
  parameter logic [WIDTH-1:0] Z_RESET = 16'o004000
) (
  input  logic             CLK2,
  input  logic             NPURST,
  input  logic [100:0]     CP,
  input  logic [11:0]      S_ADDR,
  input  logic [WIDTH-1:0] WRITE_BUS,
  output logic [WIDTH-1:0] AREG_RD_BUS,
  output logic [WIDTH-1:0] QREG_RD_BUS,
  output logic [WIDTH-1:0] ZREG_RD_BUS,
  output logic [WIDTH-1:0] LPREG_RD_BUS,
  output logic [WIDTH-1:0] B_RD_BUS,
  output logic             OVF,
  output logic             WR_STB
);

  // Control pulse positions within CP.
  localparam int unsigned CpWa     = 3;
  localparam int unsigned CpWq     = 7;
  localparam int unsigned CpWz     = 12;
  localparam int unsigned CpWlp    = 19;
  localparam int unsigned CpWb     = 27;
  localparam int unsigned CpWsc    = 40;
  localparam int unsigned CpZinc   = 58;
  localparam int unsigned CpClrovf = 77;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [WIDTH-1:0] lp_q, lp_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             ovf_q, ovf_d;
  logic             wr_stb_q, wr_stb_d;

  logic             wsc;
  logic             ld_a, ld_q, ld_z, ld_lp, ld_b;
  logic             zinc, clrovf;
  logic [WIDTH-1:0] lp_val;
  logic             bus_ovf;

  // Only a handful of CP bits belong to this block.
  logic unused_cp;
  assign unused_cp = ^CP;

  always_comb begin
    wsc    = ~CP[CpWsc];
    zinc   = ~CP[CpZinc];
    clrovf = ~CP[CpClrovf];
    ld_a   = ~CP[CpWa]  | (wsc & (S_ADDR == 12'd0));
    ld_q   = ~CP[CpWq]  | (wsc & (S_ADDR == 12'd1));
    ld_z   = ~CP[CpWz]  | (wsc & (S_ADDR == 12'd2));
    ld_lp  = ~CP[CpWlp] | (wsc & (S_ADDR == 12'd3));
    ld_b   = ~CP[CpWb];

    // Right shift that keeps the sign and rotates bit 0 into the bit below the sign.
    lp_val  = {WRITE_BUS[WIDTH-1], WRITE_BUS[0], WRITE_BUS[WIDTH-2:1]};
    bus_ovf = WRITE_BUS[WIDTH-1] ^ WRITE_BUS[WIDTH-2];
  end

  always_comb begin
    a_d      = ld_a  ? WRITE_BUS : a_q;
    q_d      = ld_q  ? WRITE_BUS : q_q;
    lp_d     = ld_lp ? lp_val    : lp_q;
    b_d      = ld_b  ? WRITE_BUS : b_q;

    // An explicit Z write takes precedence over the increment.
    z_d = z_q;
    if (ld_z) begin
      z_d = WRITE_BUS;
    end else if (zinc) begin
      z_d = z_q + WIDTH'(1);
    end

    // Setting beats clearing when both happen on the same edge.
    ovf_d = ovf_q;
    if (ld_a && bus_ovf) begin
      ovf_d = 1'b1;
    end else if (clrovf) begin
      ovf_d = 1'b0;
    end

    wr_stb_d = ld_a | ld_q | ld_z | ld_lp | ld_b;
  end

  always_ff @(posedge CLK2 or negedge NPURST) begin
    if (!NPURST) begin
      a_q      <= '0;
      q_q      <= '0;
      z_q      <= Z_RESET;
      lp_q     <= '0;
      b_q      <= '0;
      ovf_q    <= 1'b0;
      wr_stb_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      q_q      <= q_d;
      z_q      <= z_d;
      lp_q     <= lp_d;
      b_q      <= b_d;
      ovf_q    <= ovf_d;
      wr_stb_q <= wr_stb_d;
    end
  end

  assign AREG_RD_BUS  = a_q;
  assign QREG_RD_BUS  = q_q;
  assign ZREG_RD_BUS  = z_q;
  assign LPREG_RD_BUS = lp_q;
  assign B_RD_BUS     = b_q;
  assign OVF          = ovf_q;
  assign WR_STB       = wr_stb_q;

endmodule

// File: tb/tb_ng_wrb.sv
// Self-checking bench for ng_wrb: directed steps and random steps, each compared
// against a behavioural model of the register file.
module tb_ng_wrb;

  // Pulse mask bit order used by the bench.
  localparam int MWa = 0, MWq = 1, MWz = 2, MWlp = 3, MWb = 4, MWsc = 5, MZinc = 6, MClr = 7;
  // CP positions of the same pulses.
  localparam int CpPos [8] = '{3, 7, 12, 19, 27, 40, 58, 77};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [100:0] cp = '1;
  logic [11:0]  s_addr = '0;
  logic [15:0]  wbus = '0;
  logic [15:0]  areg, qreg, zreg, lpreg, breg;
  logic         ovf, wr_stb;

  int errors = 0;
  int checks = 0;

  // Model state.
  logic [15:0] m_a, m_q, m_z, m_lp, m_b;
  logic        m_ovf, m_stb;

  ng_wrb dut (
    .CLK2        (clk),
    .NPURST      (rst_n),
    .CP          (cp),
    .S_ADDR      (s_addr),
    .WRITE_BUS   (wbus),
    .AREG_RD_BUS (areg),
    .QREG_RD_BUS (qreg),
    .ZREG_RD_BUS (zreg),
    .LPREG_RD_BUS(lpreg),
    .B_RD_BUS    (breg),
    .OVF         (ovf),
    .WR_STB      (wr_stb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string step);
    check({step, ":A"},   areg,           m_a);
    check({step, ":Q"},   qreg,           m_q);
    check({step, ":Z"},   zreg,           m_z);
    check({step, ":LP"},  lpreg,          m_lp);
    check({step, ":B"},   breg,           m_b);
    check({step, ":OVF"}, {15'd0, ovf},    {15'd0, m_ovf});
    check({step, ":STB"}, {15'd0, wr_stb}, {15'd0, m_stb});
  endtask

  task automatic model_reset();
    m_a = 0; m_q = 0; m_lp = 0; m_b = 0;
    m_z = 16'o004000;
    m_ovf = 0; m_stb = 0;
  endtask

  // Behavioural effect of one CLK2 edge.
  task automatic model_edge(input logic [15:0] bus, input logic [7:0] m, input logic [11:0] sa);
    int  zi;
    bit  wr_a, wr_q, wr_z, wr_lp, wr_b, bad;
    wr_a  = m[MWa]  || (m[MWsc] && sa == 0);
    wr_q  = m[MWq]  || (m[MWsc] && sa == 1);
    wr_z  = m[MWz]  || (m[MWsc] && sa == 2);
    wr_lp = m[MWlp] || (m[MWsc] && sa == 3);
    wr_b  = m[MWb];
    // Not representable as a 15-bit signed value once shifted: top two bits differ.
    bad = (bus >= 16'h4000) && (bus < 16'hC000);
    if (wr_a) m_a = bus;
    if (wr_q) m_q = bus;
    if (wr_b) m_b = bus;
    if (wr_lp) m_lp = (bus & 16'h8000) | ((bus & 16'h0001) << 14) | ((bus >> 1) & 16'h3FFF);
    if (wr_z) m_z = bus;
    else if (m[MZinc]) begin
      zi  = (int'(m_z) + 1) % 65536;
      m_z = zi[15:0];
    end
    if (wr_a && bad) m_ovf = 1;
    else if (m[MClr]) m_ovf = 0;
    m_stb = wr_a || wr_q || wr_z || wr_lp || wr_b;
  endtask

  task automatic drive(input logic [15:0] bus, input logic [7:0] m, input logic [11:0] sa);
    cp = '1;
    for (int i = 0; i < 8; i++) if (m[i]) cp[CpPos[i]] = 1'b0;
    wbus   = bus;
    s_addr = sa;
  endtask

  // Drive at negedge, sample 1 time unit after the following posedge.
  task automatic step(input string tag, input logic [15:0] bus, input logic [7:0] m,
                      input logic [11:0] sa);
    @(negedge clk);
    drive(bus, m, sa);
    @(posedge clk);
    #1;
    model_edge(bus, m, sa);
    check_all(tag);
  endtask

  initial begin
    logic [7:0]  rm;
    logic [11:0] rsa;
    // Reset state.
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check("reset_z_const", zreg, 16'o004000);
    @(negedge clk);
    rst_n = 1'b1;

    // WA and WQ together.
    step("wa_wq", 16'o012345, 8'b0000_0011, 12'd0);
    check("wa_wq_a_const", areg, 16'o012345);
    check("wa_wq_q_const", qreg, 16'o012345);
    check("wa_wq_stb_const", {15'd0, wr_stb}, 16'd1);
    step("idle1", 16'hBEEF, 8'b0, 12'd0);
    check("idle_stb_const", {15'd0, wr_stb}, 16'd0);

    // LP shift rule.
    step("wlp", 16'b1000000000000011, 8'b0000_1000, 12'd0);
    check("wlp_const", lpreg, 16'b1100000000000001);
    step("wb", 16'h5A5A, 8'b0001_0000, 12'd0);

    // Asynchronous reset in the middle of a write cycle.
    @(negedge clk);
    drive(16'h1234, 8'b0001_1111, 12'd0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    @(negedge clk);
    drive(16'h0, 8'b0, 12'd0);
    rst_n = 1'b1;

    // Z: addressed write beats increment, then increments and wrap.
    step("wsc_z_inc", 16'o000100, 8'b0110_0000, 12'd2);
    check("wsc_z_const", zreg, 16'o000100);
    step("zinc1", 16'h0, 8'b0100_0000, 12'd0);
    step("zinc2", 16'h0, 8'b0100_0000, 12'd0);
    check("zinc2_const", zreg, 16'o000102);
    check("zinc_stb_const", {15'd0, wr_stb}, 16'd0);
    step("wz_ffff", 16'hFFFF, 8'b0000_0100, 12'd0);
    step("zinc_wrap", 16'h0, 8'b0100_0000, 12'd0);
    check("zwrap_const", zreg, 16'h0000);

    // Addressed write to an unmapped address.
    step("wsc_bad", 16'h7777, 8'b0010_0000, 12'o0010);
    check("wsc_bad_stb_const", {15'd0, wr_stb}, 16'd0);

    // Overflow set / hold / clear / set-beats-clear.
    step("ovf_set", 16'o040000, 8'b0000_0001, 12'd0);
    check("ovf_set_const", {15'd0, ovf}, 16'd1);
    step("ovf_hold", 16'o000001, 8'b0000_0001, 12'd0);
    check("ovf_hold_const", {15'd0, ovf}, 16'd1);
    step("ovf_clr", 16'h0, 8'b1000_0000, 12'd0);
    check("ovf_clr_const", {15'd0, ovf}, 16'd0);
    step("ovf_race", 16'o100000, 8'b1000_0001, 12'd0);
    check("ovf_race_const", {15'd0, ovf}, 16'd1);

    // Addressed writes to every mapped register.
    for (int k = 0; k < 4; k++) step("wsc_sweep", 16'(16'h1111 * (k + 3)), 8'b0010_0000, 12'(k));

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      rm = '0;
      for (int i = 0; i < 8; i++) rm[i] = ($urandom_range(0, 3) == 0);
      rsa = ($urandom_range(0, 3) != 0) ? 12'($urandom_range(0, 4)) : 12'($urandom);
      step("rand", 16'($urandom), rm, rsa);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
